// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
//   Frame controller sitting behind a UART receiver. Parses frames of the form
//   SOF, LEN, LEN payload bytes, XOR checksum (seeded with LEN). A verified
//   payload is held for a downstream reader until it is acknowledged.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous, active-high reset
//   rx_data_i      received byte
//   rx_valid_i     byte strobe (a long strobe counts as one byte)
//   frame_ack_i    reader releases the held frame (level, sampled)
//   rd_addr_i      payload read index
//   rd_data_o      payload[rd_addr_i], 8'h00 when rd_addr_i >= frame_len_o
//   frame_valid_o  verified frame held
//   frame_len_o    payload length of held frame, 0 when none held
//   busy_o         frame in progress (LEN / PAYLOAD / CHECK)
//   err_len_o      pulse: LEN of 0 or above MAX_LEN
//   err_crc_o      pulse: checksum mismatch
//   err_timeout_o  pulse: inter-byte gap expired mid-frame
//   overrun_o      pulse: byte dropped while a frame is held
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter int          CLK_RATE     = 100000000,
    parameter int          BAUD_RATE    = 9600,
    parameter int          TIMEOUT_BITS = 20,
    parameter int          MAX_LEN      = 16,
    parameter logic [7:0]  SOF          = 8'hA5,
    localparam int         AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic          frame_ack_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          frame_valid_o,
    output logic [7:0]    frame_len_o,
    output logic          busy_o,
    output logic          err_len_o,
    output logic          err_crc_o,
    output logic          err_timeout_o,
    output logic          overrun_o
);

    localparam int          TO_CYC  = (CLK_RATE / BAUD_RATE) * TIMEOUT_BITS;
    localparam logic [31:0] TO_LAST = 32'(TO_CYC - 1);
    localparam logic [8:0]  MAXL    = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t      state_q;
    logic        rx_valid_q;
    logic [7:0]  len_q;
    logic [7:0]  chk_q;
    logic [AW:0] idx_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        frame_valid_q;
    logic [7:0]  frame_len_q;
    logic        busy_q;
    logic        err_len_q;
    logic        err_crc_q;
    logic        err_timeout_q;
    logic        overrun_q;
    logic [7:0]  mem_q [MAX_LEN];

    logic        ev;
    logic        active;
    logic        len_ok;
    logic        last_pl;

    // Rising edge of the strobe is the byte event.
    assign ev      = rx_valid_i & ~rx_valid_q;
    assign active  = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign len_ok  = (rx_data_i != 8'h00) && ({1'b0, rx_data_i} <= MAXL);
    assign last_pl = (9'(idx_q) == (9'(len_q) - 9'd1));
    assign cnt_d   = cnt_q + 32'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            rx_valid_q    <= 1'b0;
            len_q         <= 8'h00;
            chk_q         <= 8'h00;
            idx_q         <= '0;
            cnt_q         <= 32'd0;
            frame_valid_q <= 1'b0;
            frame_len_q   <= 8'h00;
            busy_q        <= 1'b0;
            err_len_q     <= 1'b0;
            err_crc_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rx_valid_q    <= rx_valid_i;
            err_len_q     <= 1'b0;
            err_crc_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;

            if (active && !ev) begin
                // Gap timer; a byte on the expiry edge takes the else branch.
                if (cnt_q == TO_LAST) begin
                    err_timeout_q <= 1'b1;
                    state_q       <= S_IDLE;
                    busy_q        <= 1'b0;
                    cnt_q         <= 32'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end else begin
                cnt_q <= 32'd0;
                case (state_q)
                    S_IDLE: begin
                        if (ev && rx_data_i == SOF) begin
                            state_q <= S_LEN;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_LEN: begin
                        if (len_ok) begin
                            len_q   <= rx_data_i;
                            chk_q   <= rx_data_i;
                            idx_q   <= '0;
                            state_q <= S_PAYLOAD;
                        end else begin
                            err_len_q <= 1'b1;
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                        end
                    end
                    S_PAYLOAD: begin
                        chk_q <= chk_q ^ rx_data_i;
                        idx_q <= idx_q + 1'b1;
                        if (last_pl) state_q <= S_CHECK;
                    end
                    S_CHECK: begin
                        busy_q <= 1'b0;
                        if (rx_data_i == chk_q) begin
                            state_q       <= S_HOLD;
                            frame_valid_q <= 1'b1;
                            frame_len_q   <= len_q;
                        end else begin
                            err_crc_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                    S_HOLD: begin
                        if (frame_ack_i) begin
                            // Release; a coincident byte is judged as in IDLE.
                            frame_valid_q <= 1'b0;
                            frame_len_q   <= 8'h00;
                            if (ev && rx_data_i == SOF) begin
                                state_q <= S_LEN;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else if (ev) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Payload store; no reset, contents only meaningful below frame_len.
    always_ff @(posedge clk_i) begin
        if (state_q == S_PAYLOAD && ev) mem_q[idx_q[AW-1:0]] <= rx_data_i;
    end

    assign rd_data_o     = (9'(rd_addr_i) < 9'(frame_len_q)) ? mem_q[rd_addr_i] : 8'h00;
    assign frame_valid_o = frame_valid_q;
    assign frame_len_o   = frame_len_q;
    assign busy_o        = busy_q;
    assign err_len_o     = err_len_q;
    assign err_crc_o     = err_crc_q;
    assign err_timeout_o = err_timeout_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames followed by random frames,
// each judged by a frame-level model (expected payload, checksum, error kind).
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int AW      = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          frame_ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          frame_valid;
    logic [7:0]    frame_len;
    logic          busy;
    logic          err_len, err_crc, err_timeout, overrun;

    int total = 0;
    int bad   = 0;
    int n_len = 0, n_crc = 0, n_to = 0, n_ovr = 0;

    uart_rx_frame_ctrl #(
        .CLK_RATE(1600), .BAUD_RATE(100), .TIMEOUT_BITS(4),
        .MAX_LEN(MAX_LEN), .SOF(8'hA5)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .frame_ack_i(frame_ack), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .frame_valid_o(frame_valid), .frame_len_o(frame_len), .busy_o(busy),
        .err_len_o(err_len), .err_crc_o(err_crc), .err_timeout_o(err_timeout),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    // Each cycle an error line is high adds one to its count.
    always @(negedge clk) begin
        if (err_len)     n_len++;
        if (err_crc)     n_crc++;
        if (err_timeout) n_to++;
        if (overrun)     n_ovr++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe held for h cycles, then one low cycle.
    task automatic send(input logic [7:0] b, input int h);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (h) tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] q[$]);
        logic [7:0] c = 8'(q.size());
        foreach (q[i]) c ^= q[i];
        return c;
    endfunction

    task automatic check_payload(input string tag, input logic [7:0] q[$]);
        foreach (q[i]) begin
            rd_addr = AW'(i);
            #1 chk({tag, "_rd"}, {24'h0, rd_data}, {24'h0, q[i]});
        end
        if (q.size() < MAX_LEN) begin
            rd_addr = AW'(q.size());
            #1 chk({tag, "_rd_past"}, {24'h0, rd_data}, 32'h0);
        end
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] held[$];
        logic [7:0] c;
        int b_len, b_crc, b_to, b_ovr;

        repeat (3) tick();
        chk("rst_valid", {31'h0, frame_valid}, 0);
        chk("rst_len",   {24'h0, frame_len}, 0);
        chk("rst_busy",  {31'h0, busy}, 0);
        chk("rst_rd",    {24'h0, rd_data}, 0);
        rst = 1'b0;
        tick();
        chk("rst_errs",  n_len + n_crc + n_to + n_ovr, 0);

        // 1: basic frame
        send(8'hA5, 1);
        chk("t1_busy", {31'h0, busy}, 1);
        pl = '{8'h11, 8'h22, 8'h33};
        send(8'h03, 1);
        foreach (pl[i]) send(pl[i], 2);
        send(xsum(pl), 3);
        chk("t1_valid", {31'h0, frame_valid}, 1);
        chk("t1_len",   {24'h0, frame_len}, 3);
        chk("t1_busy_done", {31'h0, busy}, 0);
        check_payload("t1", pl);
        ack();
        chk("t1_ack_valid", {31'h0, frame_valid}, 0);
        chk("t1_ack_len",   {24'h0, frame_len}, 0);

        // 2: junk ignored, bad checksum, then good frame
        b_crc = n_crc;
        send(8'h00, 1); send(8'hFF, 1);
        chk("t2_idle_busy", {31'h0, busy}, 0);
        send(8'hA5, 1); send(8'h02, 1); send(8'hAA, 1); send(8'h55, 1); send(8'h00, 1);
        chk("t2_crc", n_crc - b_crc, 1);
        chk("t2_valid", {31'h0, frame_valid}, 0);
        chk("t2_busy",  {31'h0, busy}, 0);
        send(8'hA5, 1); send(8'h01, 1); send(8'h7E, 1); send(8'h7F, 1);
        chk("t2b_valid", {31'h0, frame_valid}, 1);
        chk("t2b_len",   {24'h0, frame_len}, 1);
        pl = '{8'h7E};
        check_payload("t2b", pl);
        ack();

        // 3: length bounds
        b_len = n_len;
        send(8'hA5, 1); send(8'h00, 1);
        chk("t3_len0", n_len - b_len, 1);
        chk("t3_len0_busy", {31'h0, busy}, 0);
        send(8'hA5, 1); send(8'h11, 1);
        chk("t3_len17", n_len - b_len, 2);
        pl = {};
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom));
        send(8'hA5, 1); send(8'h10, 1);
        foreach (pl[i]) send(pl[i], 1);
        send(xsum(pl), 1);
        chk("t3_valid", {31'h0, frame_valid}, 1);
        chk("t3_len",   {24'h0, frame_len}, 16);
        check_payload("t3", pl);
        ack();

        // 4: inter-byte timeout, and a byte exactly on the expiry edge
        b_to = n_to;
        send(8'hA5, 1); send(8'h02, 1); send(8'hAA, 1);
        repeat (62) tick();
        chk("t4_pre_to", n_to - b_to, 0);
        chk("t4_pre_busy", {31'h0, busy}, 1);
        tick();
        chk("t4_to_pulse", {31'h0, err_timeout}, 1);
        chk("t4_to_busy", {31'h0, busy}, 0);
        repeat (4) tick();
        chk("t4_to_once", n_to - b_to, 1);
        send(8'hA5, 1); send(8'h02, 1); send(8'hAA, 1);
        repeat (62) tick();
        send(8'hBB, 1);
        chk("t4_edge_no_to", n_to - b_to, 1);
        pl = '{8'hAA, 8'hBB};
        send(xsum(pl), 1);
        chk("t4_edge_valid", {31'h0, frame_valid}, 1);

        // 5: overrun while held, ack coincident with SOF
        b_ovr = n_ovr;
        send(8'h5C, 1);
        chk("t5_ovr", n_ovr - b_ovr, 1);
        chk("t5_ovr_valid", {31'h0, frame_valid}, 1);
        chk("t5_ovr_len", {24'h0, frame_len}, 2);
        check_payload("t5", pl);
        frame_ack = 1'b1; rx_data = 8'hA5; rx_valid = 1'b1;
        tick();
        frame_ack = 1'b0; rx_valid = 1'b0;
        chk("t5_ack_valid", {31'h0, frame_valid}, 0);
        chk("t5_ack_busy",  {31'h0, busy}, 1);
        tick();
        chk("t5_ack_no_ovr", n_ovr - b_ovr, 1);
        send(8'h01, 1); send(8'h42, 1); send(8'h43, 1);
        chk("t5_next_valid", {31'h0, frame_valid}, 1);
        ack();

        // 6: asynchronous reset mid-payload
        b_len = n_len; b_crc = n_crc; b_to = n_to; b_ovr = n_ovr;
        send(8'hA5, 1); send(8'h04, 1); send(8'h11, 1); send(8'h22, 1);
        chk("t6_pre_busy", {31'h0, busy}, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t6_outs", {frame_valid, busy, err_len, err_crc, err_timeout, overrun, frame_len}, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("t6_no_err", (n_len - b_len) + (n_crc - b_crc) + (n_to - b_to) + (n_ovr - b_ovr), 0);
        pl = '{8'h01, 8'h02};
        send(8'hA5, 1); send(8'h02, 1); send(8'h01, 1); send(8'h02, 1); send(xsum(pl), 1);
        chk("t6_valid", {31'h0, frame_valid}, 1);
        check_payload("t6", pl);
        ack();

        // Random frames against the frame-level model
        for (int f = 0; f < 24; f++) begin
            int kind = $urandom_range(0, 9);
            int ln;
            b_len = n_len; b_crc = n_crc;
            if (kind == 0) ln = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
            else           ln = $urandom_range(1, MAX_LEN);
            send(8'hA5, $urandom_range(1, 3));
            repeat ($urandom_range(0, 3)) tick();
            send(8'(ln), $urandom_range(1, 3));
            if (kind == 0) begin
                chk("rnd_errlen", n_len - b_len, 1);
                chk("rnd_errlen_busy", {31'h0, busy}, 0);
                continue;
            end
            pl = {};
            for (int i = 0; i < ln; i++) pl.push_back(8'($urandom));
            foreach (pl[i]) begin
                send(pl[i], $urandom_range(1, 3));
                repeat ($urandom_range(0, 3)) tick();
            end
            c = xsum(pl);
            if (kind <= 3) c ^= 8'($urandom_range(1, 255));
            send(c, $urandom_range(1, 3));
            if (kind <= 3) begin
                chk("rnd_crc", n_crc - b_crc, 1);
                chk("rnd_crc_valid", {31'h0, frame_valid}, 0);
            end else begin
                held = pl;
                chk("rnd_valid", {31'h0, frame_valid}, 1);
                chk("rnd_len", {24'h0, frame_len}, ln);
                check_payload("rnd", held);
                ack();
                chk("rnd_ack", {31'h0, frame_valid}, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
